// File: rtl/addr_byte_assembler.sv
// rtl/addr_byte_assembler.sv - assembles lo/hi bytes or an increment into a 16-bit register load
module addr_byte_assembler #(
    parameter logic [15:0] RESET_VECTOR   = 16'h0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd32
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        start_load,
    input  logic        incr,
    input  logic [15:0] addr_cur,
    output logic [15:0] addr_out,
    output logic        addr_load,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic        terr_q, terr_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  lo_q, lo_d;
    logic        expired;

    // Timer holds the number of byte-less cycles already spent in the current wait state.
    assign expired = (TIMEOUT_CYCLES != 8'd0) && (timer_q == TIMEOUT_CYCLES - 8'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        load_d  = 1'b0;
        terr_d  = terr_q;
        timer_d = timer_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = WAIT_LO;
                    timer_d = 8'd0;
                    terr_d  = 1'b0;
                end else if (incr) begin
                    addr_d  = addr_cur + 16'd1;
                    load_d  = 1'b1;
                    state_d = COMMIT;
                end
            end
            WAIT_LO, WAIT_HI: begin
                if (byte_valid) begin
                    timer_d = 8'd0;
                    if (state_q == WAIT_LO) begin
                        lo_d    = byte_in;
                        state_d = WAIT_HI;
                    end else begin
                        addr_d  = {byte_in, lo_q};
                        load_d  = 1'b1;
                        state_d = COMMIT;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= IDLE;
            addr_q  <= RESET_VECTOR;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            timer_q <= 8'd0;
            lo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            timer_q <= timer_d;
            lo_q    <= lo_d;
        end
    end

    assign byte_ready  = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    assign addr_out    = addr_q;
    assign addr_load   = load_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_addr_byte_assembler.sv
// tb/tb_addr_byte_assembler.sv - directed checks of addr_byte_assembler with 32- and 4-cycle timeouts
module tb_addr_byte_assembler;

    logic        clock = 1'b0;
    logic        clear_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        start_load;
    logic        incr;
    logic [15:0] addr_cur;

    logic        byte_ready, addr_load, busy, timeout_err;
    logic [15:0] addr_out;
    logic        byte_ready4, addr_load4, busy4, timeout_err4;
    logic [15:0] addr_out4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    addr_byte_assembler #(.RESET_VECTOR(16'h0000), .TIMEOUT_CYCLES(8'd32)) dut (
        .clock(clock), .clear_n(clear_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .start_load(start_load), .incr(incr), .addr_cur(addr_cur),
        .addr_out(addr_out), .addr_load(addr_load), .busy(busy), .timeout_err(timeout_err)
    );

    addr_byte_assembler #(.RESET_VECTOR(16'h0000), .TIMEOUT_CYCLES(8'd4)) dut4 (
        .clock(clock), .clear_n(clear_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready4), .start_load(start_load), .incr(incr), .addr_cur(addr_cur),
        .addr_out(addr_out4), .addr_load(addr_load4), .busy(busy4), .timeout_err(timeout_err4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        step();
        step();
        clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        start_load = 1'b0; incr = 1'b0; addr_cur = 16'h0000;
        do_reset();
        check("rst_addr", addr_out, 16'h0000);
        check("rst_load", addr_load, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_terr", timeout_err, 0);

        // Test 1: basic two-byte load
        start_load = 1'b1; step(); start_load = 1'b0;
        check("t1_ready_lat", byte_ready, 1);
        byte_in = 8'h34; byte_valid = 1'b1; step();
        check("t1_ready_hi", byte_ready, 1);
        check("t1_noload_lo", addr_load, 0);
        byte_in = 8'h12; step();
        byte_valid = 1'b0;
        check("t1_load", addr_load, 1);
        check("t1_addr", addr_out, 16'h1234);
        check("t1_commit_ready", byte_ready, 0);
        step();
        check("t1_load_off", addr_load, 0);
        check("t1_busy_off", busy, 0);
        check("t1_addr_hold", addr_out, 16'h1234);

        // Test 2: increment with carry and wrap
        addr_cur = 16'h00FF; incr = 1'b1; step(); incr = 1'b0;
        check("t2_load", addr_load, 1);
        check("t2_addr", addr_out, 16'h0100);
        step();
        check("t2_load_off", addr_load, 0);
        addr_cur = 16'hFFFF; incr = 1'b1; step(); incr = 1'b0;
        check("t2_wrap_load", addr_load, 1);
        check("t2_wrap_addr", addr_out, 16'h0000);
        step();
        check("t2_wrap_load_off", addr_load, 0);

        // Test 3: timeout on dut4 (TIMEOUT_CYCLES=4) while waiting for the high byte
        start_load = 1'b1; step(); start_load = 1'b0;
        byte_in = 8'hAA; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_waiting_busy", busy4, 1);
            check("t3_waiting_load", addr_load4, 0);
        end
        step();
        check("t3_idle", busy4, 0);
        check("t3_terr", timeout_err4, 1);
        check("t3_addr", addr_out4, 16'h0000);
        check("t3_noload", addr_load4, 0);
        check("t3_long_busy", busy, 1);
        step();
        check("t3_terr_sticky", timeout_err4, 1);
        start_load = 1'b1; step(); start_load = 1'b0;
        check("t3_terr_clr", timeout_err4, 0);
        check("t3_restart", byte_ready4, 1);
        do_reset();

        // Test 4: start_load beats incr; incr ignored while busy
        addr_cur = 16'h5555; start_load = 1'b1; incr = 1'b1; step();
        start_load = 1'b0; incr = 1'b0;
        check("t4_ready", byte_ready, 1);
        check("t4_noinc", addr_load, 0);
        check("t4_addr", addr_out, 16'h0000);
        byte_in = 8'h10; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        incr = 1'b1; step(); incr = 1'b0;
        check("t4_incr_ign", addr_load, 0);
        check("t4_still_hi", byte_ready, 1);
        byte_in = 8'h20; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        check("t4_load", addr_load, 1);
        check("t4_addr2", addr_out, 16'h2010);
        step();

        // Test 5: reset mid-sequence discards captured low byte
        start_load = 1'b1; step(); start_load = 1'b0;
        byte_in = 8'h55; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        check("t5_in_hi", byte_ready, 1);
        clear_n = 1'b0; step(); clear_n = 1'b1;
        check("t5_addr", addr_out, 16'h0000);
        check("t5_load", addr_load, 0);
        check("t5_busy", busy, 0);
        byte_in = 8'h77; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        check("t5_drop", busy, 0);
        start_load = 1'b1; step(); start_load = 1'b0;
        byte_in = 8'h01; byte_valid = 1'b1; step();
        byte_in = 8'h80; step(); byte_valid = 1'b0;
        check("t5_load2", addr_load, 1);
        check("t5_addr2", addr_out, 16'h8001);
        step();

        // Test 6: stall between bytes
        start_load = 1'b1; step(); start_load = 1'b0;
        byte_in = 8'hCD; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stall_load", addr_load, 0);
            check("t6_stall_ready", byte_ready, 1);
        end
        byte_in = 8'hEF; byte_valid = 1'b1; step(); byte_valid = 1'b0;
        check("t6_load", addr_load, 1);
        check("t6_addr", addr_out, 16'hEFCD);
        check("t6_terr", timeout_err, 0);
        step();
        check("t6_load_off", addr_load, 0);
        check("t6_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
